// File: rtl/ctrl_bubble_stage.sv
// Pipeline control register that passes the decoded control word downstream. On a load-use
// hazard it inserts a run of zeroed bubble cycles and holds the upstream stages through stall_o.
module ctrl_bubble_stage #(
    parameter int unsigned WB_W        = 2,
    parameter int unsigned MEM_W       = 2,
    parameter int unsigned EX_W        = 4,
    parameter int unsigned MAX_BUBBLES = 3,
    parameter int unsigned CNT_W       = $clog2(MAX_BUBBLES + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [WB_W+MEM_W+EX_W-1:0] control_i,
    input  logic                       valid_i,
    input  logic                       hazard_i,
    input  logic [CNT_W-1:0]           bubble_len_i,
    input  logic                       flush_i,
    output logic [WB_W-1:0]            control_WB_o,
    output logic [MEM_W-1:0]           control_MEM_o,
    output logic [EX_W-1:0]            control_EX_o,
    output logic                       valid_o,
    output logic                       stall_o,
    output logic [15:0]                bubble_cnt_o
);

    localparam int unsigned CTRL_W = WB_W + MEM_W + EX_W;
    localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_BUBBLES);
    localparam logic [CNT_W-1:0] OneLen = CNT_W'(1);

    typedef enum logic {StPass, StBubble} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  rem_q;
    logic [WB_W-1:0]   wb_q;
    logic [MEM_W-1:0]  mem_q;
    logic [EX_W-1:0]   ex_q;
    logic              valid_q;
    logic [15:0]       bubble_cnt_q;
    logic [CNT_W-1:0]  eff_len;

    // A length of 0 still means one bubble; longer requests are capped.
    always_comb begin
        eff_len = bubble_len_i;
        if (bubble_len_i == '0) begin
            eff_len = OneLen;
        end else if (bubble_len_i > MaxLen) begin
            eff_len = MaxLen;
        end
    end

    // Stall exactly in the cycles that load a bubble, so the two runs always match in length.
    always_comb begin
        stall_o = rst_i && !flush_i && ((state_q == StBubble) || (valid_i && hazard_i));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StPass;
            rem_q        <= '0;
            wb_q         <= '0;
            mem_q        <= '0;
            ex_q         <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else if (flush_i) begin
            state_q <= StPass;
            rem_q   <= '0;
            wb_q    <= '0;
            mem_q   <= '0;
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else if (state_q == StBubble) begin
            wb_q    <= '0;
            mem_q   <= '0;
            ex_q    <= '0;
            valid_q <= 1'b0;
            rem_q   <= rem_q - OneLen;
            if (rem_q <= OneLen) begin
                state_q <= StPass;
            end
            if (bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
        end else if (valid_i && hazard_i) begin
            wb_q    <= '0;
            mem_q   <= '0;
            ex_q    <= '0;
            valid_q <= 1'b0;
            if (eff_len > OneLen) begin
                state_q <= StBubble;
                rem_q   <= eff_len - OneLen;
            end else begin
                state_q <= StPass;
                rem_q   <= '0;
            end
            if (bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
        end else begin
            wb_q    <= control_i[CTRL_W-1 -: WB_W];
            mem_q   <= control_i[EX_W+MEM_W-1 -: MEM_W];
            ex_q    <= control_i[EX_W-1:0];
            valid_q <= valid_i;
        end
    end

    assign control_WB_o  = wb_q;
    assign control_MEM_o = mem_q;
    assign control_EX_o  = ex_q;
    assign valid_o       = valid_q;
    assign bubble_cnt_o  = bubble_cnt_q;

endmodule
